// File: rtl/gpu_instruction_scheduler.sv
// gpu_instruction_scheduler: assembles host bytes into 32-bit instructions, buffers and issues them.
// Define VBLANK_GATE_EN to restrict issue to vertical blanking.
module gpu_instruction_scheduler #(
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    input  logic               i_vblank,
    output logic [31:0]        o_instruction,
    output logic               o_instruction_ready,
    output logic [FIFO_AW:0]   o_fifo_count,
    output logic               o_timeout
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [1:0]          idx, cur_idx;
    logic [23:0]         partial;
    logic [TW-1:0]       timer;
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [31:0]         mem [DEPTH];
    logic [FIFO_AW:0]    count_next;
    logic                window_open, accept, expire, word_done, flush, push, pop;

`ifdef VBLANK_GATE_EN
    assign window_open = i_vblank;
`else
    logic unused_vblank;
    assign unused_vblank = i_vblank;
    assign window_open   = 1'b1;
`endif

    // reset asserts immediately, releases two edges later
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    always_comb begin
        accept     = i_byte_valid && o_byte_ready;
        expire     = idx != 2'd0 && timer == TW'(TIMEOUT_CYC);
        cur_idx    = expire ? 2'd0 : idx;
        word_done  = accept && cur_idx == 2'd3;
        flush      = word_done && partial[7:0] == 8'hFF;
        push       = word_done && partial[7:0] != 8'h00 && partial[7:0] != 8'hFF;
        pop        = !flush && o_fifo_count != '0 && window_open;
        count_next = flush ? '0 : o_fifo_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end

    always_ff @(posedge i_clk or negedge rst_n)
        if (!rst_n) begin
            idx                 <= '0;
            partial             <= '0;
            timer               <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_fifo_count        <= '0;
            o_byte_ready        <= 1'b0;
            o_instruction       <= '0;
            o_instruction_ready <= 1'b0;
            o_timeout           <= 1'b0;
        end else begin
            idx   <= accept ? cur_idx + 2'd1 : cur_idx;
            if (accept && cur_idx != 2'd3) partial[8*cur_idx +: 8] <= i_byte;
            timer <= (accept || expire || idx == 2'd0) ? '0 : timer + TW'(1);
            o_timeout    <= expire;
            wr_ptr       <= flush ? '0 : wr_ptr + FIFO_AW'(push);
            rd_ptr       <= flush ? '0 : rd_ptr + FIFO_AW'(pop);
            o_fifo_count <= count_next;
            o_byte_ready <= count_next != (FIFO_AW+1)'(DEPTH);
            if (pop) o_instruction <= mem[rd_ptr];
            o_instruction_ready <= pop;
        end

    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= {i_byte, partial};
endmodule
